rx_ieee: RTL and testbench

RX_IEEE -- requirements
Module: rx_ieee

---
 rtl/rx_ieee.sv | 181 ++++++++++++++++++
 tb/tb_rx_ieee.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rx_ieee.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rx_ieee                                                       |
// | Description : Oversampling serial receiver, start + DATA_BITS (LSB first)   |
// |               + optional even parity (macro RX_PARITY_EN) + one stop bit.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rx_ieee #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int c_TMR_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_TMR_W-1:0] c_TMR_HALF = c_TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_FULL = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } t_state;

    t_state                 r_state;
    t_state                 w_state_nxt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rx_prev;
    logic [c_TMR_W-1:0]     r_timer;
    logic [c_IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0]   r_shift;

    logic                   w_fall;
    logic                   w_sample;
    logic                   w_last_bit;
    logic                   w_shift_en;
    logic                   w_stop_ok;
    logic                   w_stop_bad;
`ifdef RX_PARITY_EN
    logic                   r_par_bad;
    logic                   w_par_smp;
`endif

    // Edge detect works on the synchronized line only; a line held low never re-arms it.
    assign w_fall     = r_rx_prev & ~r_sync2;
    assign w_sample   = (r_state == S_START) ? (r_timer == c_TMR_HALF)
                                             : (r_timer == c_TMR_FULL);
    assign w_last_bit = (r_idx == c_IDX_LAST);
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
`ifdef RX_PARITY_EN
        w_par_smp   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_sample) w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_sample) begin
                    w_shift_en = 1'b1;
                    if (w_last_bit) begin
`ifdef RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (w_sample) begin
                    w_par_smp   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_sample) begin
                    w_stop_ok   = r_sync2;
                    w_stop_bad  = ~r_sync2;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == S_IDLE || w_sample) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TMR_ONE;
            end
            if (w_shift_en) begin
                r_idx   <= w_last_bit ? '0 : (r_idx + c_IDX_ONE);
                r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= w_stop_ok;
            frame_err  <= w_stop_bad;
            if (w_stop_ok) data_out <= r_shift;
        end
    end

`ifdef RX_PARITY_EN
    // Mismatch is held until the stop bit so it reports alongside data_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par_bad  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (w_par_smp) r_par_bad <= r_sync2 ^ (^r_shift);
            parity_err <= w_stop_ok & r_par_bad;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_ieee.sv
`default_nettype none
// Testbench for rx_ieee: randomized frames, scoreboard of expected receive events.
module tb_rx_ieee;
    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;
`ifdef RX_PARITY_EN
    logic          parity_err;
`endif

    rx_ieee #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ferr;
        logic          perr;
        logic [DB-1:0] data;
    } exp_t;

    exp_t          q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [DB-1:0] last_good = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    // Reference: a good stop bit delivers the byte, a bad one reports the previous byte.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
        exp_t e;
        e.ferr = ~stop_b;
        e.data = stop_b ? d : last_good;
`ifdef RX_PARITY_EN
        e.perr = stop_b && (par_b != ^d);
`else
        e.perr = 1'b0;
`endif
        if (stop_b) last_good = d;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit(par_b);
`endif
        drive_bit(stop_b);
    endtask

    always @(negedge clk) begin
        if (reset_n && (data_valid || frame_err)) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b data=%0h, expected none",
                         data_valid, frame_err, data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_valid", {31'd0, data_valid}, {31'd0, ~e.ferr});
                check("pulse_ferr", {31'd0, frame_err}, {31'd0, e.ferr});
                check("pulse_data", {24'd0, data_out}, {24'd0, e.data});
`ifdef RX_PARITY_EN
                check("pulse_perr", {31'd0, parity_err}, {31'd0, e.perr});
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] v;
        logic [DB-1:0] d;
        logic          s;
        logic          p;
        int            gap;

        repeat (3) @(negedge clk);
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0);
        drive_bit(1'b1);
        check("busy_after_a5", {31'd0, busy}, 32'd0);
        check("hold_a5", {24'd0, data_out}, 32'hA5);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive_bit(1'b1);

        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_hold", {24'd0, data_out}, 32'hFF);
        drive_bit(1'b1);

        send_frame(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("break_hold", {24'd0, data_out}, 32'hFF);

        v = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[i]);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_data", {24'd0, data_out}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_valid", {31'd0, data_valid}, 32'd0);
        last_good = '0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        drive_bit(1'b1);
        send_frame(8'h81, 1'b1, 1'b0);
        drive_bit(1'b1);
        check("after_reset_81", {24'd0, data_out}, 32'h81);

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bit(1'b1);
`endif

        for (int n = 0; n < 16; n++) begin
            d   = 8'($urandom);
            s   = ($urandom_range(0, 4) != 0);
            p   = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            gap = s ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(d, s, p);
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
        end
        drive_bit(1'b1);

        repeat (3 * CPB) @(negedge clk);
        check("scoreboard_drained", q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
